// File: rtl/trap_collector_pkg.sv
// rtl/trap_collector_pkg.sv - shared core definitions: trap info record, FSM states, ROB age compare
`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif

package trap_collector_pkg;

  localparam int XLEN      = 64;
  localparam int AGE_IDX_W = 16;

  typedef logic [1:0] trap_state_t;
  localparam trap_state_t ST_IDLE  = 2'd0;
  localparam trap_state_t ST_HOLD  = 2'd1;
  localparam trap_state_t ST_ISSUE = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] tval;
  } trapInfo_t;

  // Differing wrap flags mean the numerically larger index was allocated first.
  function automatic logic is_older(input logic a_flag, input logic [AGE_IDX_W-1:0] a_idx,
                                    input logic b_flag, input logic [AGE_IDX_W-1:0] b_idx);
    if (a_flag == b_flag) return a_idx < b_idx;
    else                  return a_idx > b_idx;
  endfunction

endpackage

// File: rtl/trap_age_select.sv
// rtl/trap_age_select.sv - combinational oldest-of-N ROB index selection tree
module trap_age_select
  import trap_collector_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int ROBW     = 5,
  localparam int CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic [CHANNELS-1:0]         vld,
  input  logic [CHANNELS-1:0][ROBW:0] rob_idx,
  output logic                        any_vld,
  output logic [CHW-1:0]              sel,
  output logic [ROBW:0]               sel_idx
);

  localparam int LVLS = $clog2(CHANNELS);
  localparam int N    = 1 << LVLS;
  localparam int PW   = N * (ROBW + 1);

  logic [N-1:0]         vld_pad;
  logic [N-1:0][ROBW:0] idx_pad;

  assign vld_pad = N'(vld);
  assign idx_pad = PW'(rob_idx);

  always_comb begin : tree
    logic           v   [N];
    logic [ROBW:0]  idx [N];
    logic [CHW-1:0] ch  [N];
    logic           take_r;
    take_r = 1'b0;
    for (int j = 0; j < N; j++) begin
      v[j]   = vld_pad[j];
      idx[j] = idx_pad[j];
      ch[j]  = CHW'(j);
    end
    // Reduced in place; the left child always carries the lower channels, so ties keep it.
    for (int w = N / 2; w >= 1; w = w / 2) begin
      for (int k = 0; k < w; k++) begin
        take_r = v[2*k+1] && (!v[2*k] ||
                 is_older(idx[2*k+1][ROBW], AGE_IDX_W'(idx[2*k+1][ROBW-1:0]),
                          idx[2*k][ROBW],   AGE_IDX_W'(idx[2*k][ROBW-1:0])));
        if (take_r) begin
          v[k]   = v[2*k+1];
          idx[k] = idx[2*k+1];
          ch[k]  = ch[2*k+1];
        end else begin
          v[k]   = v[2*k];
          idx[k] = idx[2*k];
          ch[k]  = ch[2*k];
        end
      end
    end
    any_vld = v[0];
    sel     = ch[0];
    sel_idx = idx[0];
  end

endmodule

// File: rtl/trap_collector.sv
// rtl/trap_collector.sv - holds the oldest reported exception and offers it to the CSR unit at commit
// Optional tval storage is enabled by defining TRAP_TVAL_EN.
`ifndef ROB_SIZE
`define ROB_SIZE 32
`endif

module trap_collector
  import trap_collector_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int ROBW     = $clog2(`ROB_SIZE)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CHANNELS-1:0]             i_rpt_vld,
  input  logic [CHANNELS-1:0][ROBW:0]     i_rpt_robIdx,
  input  logic [CHANNELS-1:0][15:0]       i_rpt_cause,
  input  logic [CHANNELS-1:0][XLEN-1:0]   i_rpt_epc,
  input  logic [CHANNELS-1:0][XLEN-1:0]   i_rpt_tval,
  input  logic                            i_flush,
  input  logic                            i_commit_vld,
  input  logic [ROBW:0]                   i_commit_robIdx,
  output logic                            o_pending,
  output logic [ROBW:0]                   o_pending_robIdx,
  output logic                            o_trap_vld,
  input  logic                            i_trap_rdy,
  output trapInfo_t                       o_trap_info
);

  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic            sel_vld;
  logic [CHW-1:0]  sel_ch;
  logic [ROBW:0]   sel_idx;
  trap_state_t     state;
  logic [ROBW:0]   held_idx;
  logic [15:0]     held_cause;
  logic [XLEN-1:0] held_epc;
  logic            sel_older;
  logic            commit_hit;
  logic            capture;
  logic            discard;

  trap_age_select #(
    .CHANNELS (CHANNELS),
    .ROBW     (ROBW)
  ) u_age_select (
    .vld     (i_rpt_vld),
    .rob_idx (i_rpt_robIdx),
    .any_vld (sel_vld),
    .sel     (sel_ch),
    .sel_idx (sel_idx)
  );

  assign sel_older  = is_older(sel_idx[ROBW],  AGE_IDX_W'(sel_idx[ROBW-1:0]),
                               held_idx[ROBW], AGE_IDX_W'(held_idx[ROBW-1:0]));
  assign commit_hit = i_commit_vld && (i_commit_robIdx == held_idx);
  // A commit match in HOLD takes priority over replacement; flush beats both.
  assign capture    = sel_vld && !i_flush &&
                      ((state == ST_IDLE) || ((state == ST_HOLD) && !commit_hit && sel_older));
  assign discard    = ((state == ST_HOLD) && i_flush) || ((state == ST_ISSUE) && i_trap_rdy);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (sel_vld && !i_flush) state <= ST_HOLD;
        ST_HOLD:  if (i_flush) state <= ST_IDLE;
                  else if (commit_hit) state <= ST_ISSUE;
        ST_ISSUE: if (i_trap_rdy) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || discard) begin
      held_idx   <= '0;
      held_cause <= '0;
      held_epc   <= '0;
    end else if (capture) begin
      held_idx   <= sel_idx;
      held_cause <= i_rpt_cause[sel_ch];
      held_epc   <= i_rpt_epc[sel_ch];
    end
  end

`ifdef TRAP_TVAL_EN
  logic [XLEN-1:0] held_tval;

  always_ff @(posedge clk) begin
    if (rst || discard) held_tval <= '0;
    else if (capture)   held_tval <= i_rpt_tval[sel_ch];
  end

  assign o_trap_info.tval = held_tval;
`else
  logic unused_tval;
  assign unused_tval      = ^i_rpt_tval;
  assign o_trap_info.tval = '0;
`endif

  assign o_pending        = (state == ST_HOLD) || (state == ST_ISSUE);
  assign o_pending_robIdx = held_idx;
  assign o_trap_vld       = (state == ST_ISSUE);
  assign o_trap_info.cause = XLEN'(held_cause);
  assign o_trap_info.epc   = held_epc;

endmodule

// File: tb/tb_trap_collector.sv
// tb/tb_trap_collector.sv - directed scoreboard bench for trap_collector
module tb_trap_collector;
  import trap_collector_pkg::*;

  localparam int CH = 4;
  localparam int RW = 5;
`ifdef TRAP_TVAL_EN
  localparam bit TVAL_ON = 1'b1;
`else
  localparam bit TVAL_ON = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      rst;
  logic [CH-1:0]             rpt_vld;
  logic [CH-1:0][RW:0]       rpt_idx;
  logic [CH-1:0][15:0]       rpt_cause;
  logic [CH-1:0][XLEN-1:0]   rpt_epc;
  logic [CH-1:0][XLEN-1:0]   rpt_tval;
  logic                      flush;
  logic                      commit_vld;
  logic [RW:0]               commit_idx;
  logic                      pending;
  logic [RW:0]               pending_idx;
  logic                      trap_vld;
  logic                      trap_rdy;
  trapInfo_t                 trap_info;

  typedef struct {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] tval;
    logic [RW:0]     idx;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   checks = 0;
  int   errors = 0;

  trap_collector #(.CHANNELS(CH), .ROBW(RW)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_rpt_vld        (rpt_vld),
    .i_rpt_robIdx     (rpt_idx),
    .i_rpt_cause      (rpt_cause),
    .i_rpt_epc        (rpt_epc),
    .i_rpt_tval       (rpt_tval),
    .i_flush          (flush),
    .i_commit_vld     (commit_vld),
    .i_commit_robIdx  (commit_idx),
    .o_pending        (pending),
    .o_pending_robIdx (pending_idx),
    .o_trap_vld       (trap_vld),
    .i_trap_rdy       (trap_rdy),
    .o_trap_info      (trap_info)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rpt_vld    = '0;
    rpt_idx    = '0;
    rpt_cause  = '0;
    rpt_epc    = '0;
    rpt_tval   = '0;
    flush      = 1'b0;
    commit_vld = 1'b0;
    commit_idx = '0;
    trap_rdy   = 1'b0;
  endtask

  task automatic report(input int ch, input logic [RW:0] idx, input logic [15:0] cause,
                        input logic [XLEN-1:0] epc, input logic [XLEN-1:0] tval);
    rpt_vld[ch]   = 1'b1;
    rpt_idx[ch]   = idx;
    rpt_cause[ch] = cause;
    rpt_epc[ch]   = epc;
    rpt_tval[ch]  = tval;
  endtask

  task automatic commit_push(input logic [RW:0] idx, input logic [15:0] cause,
                             input logic [XLEN-1:0] epc, input logic [XLEN-1:0] tval);
    exp_t e;
    commit_vld = 1'b1;
    commit_idx = idx;
    e.cause = {{(XLEN-16){1'b0}}, cause};
    e.epc   = epc;
    e.tval  = TVAL_ON ? tval : '0;
    e.idx   = idx;
    sb.push_back(e);
  endtask

  task automatic expect_trap(input string tag);
    int n = 0;
    while (!trap_vld && n < 8) begin
      tick();
      n++;
    end
    check({tag, "_vld"}, trap_vld, 1);
    if (trap_vld) begin
      check({tag, "_sb_size"}, sb.size(), 1);
      if (sb.size() > 0) begin
        last = sb.pop_front();
        check({tag, "_cause"}, trap_info.cause, last.cause);
        check({tag, "_epc"},   trap_info.epc,   last.epc);
        check({tag, "_tval"},  trap_info.tval,  last.tval);
        check({tag, "_idx"},   pending_idx,     last.idx);
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    tick();
    check("rst_pending",  pending,         0);
    check("rst_trap_vld", trap_vld,        0);
    check("rst_idx",      pending_idx,     0);
    check("rst_info",     trap_info.cause | trap_info.epc | trap_info.tval, 0);
    rst = 1'b0;
    tick();

    // load fault on ch2, then commit
    report(2, 6'd5, 16'd5, 64'h1000, 64'hdead);
    tick();
    idle_inputs();
    check("basic_pending", pending, 1);
    check("basic_idx", pending_idx, 5);
    commit_push(6'd5, 16'd5, 64'h1000, 64'hdead);
    tick();
    idle_inputs();
    check("basic_issue_latency", trap_vld, 1);
    expect_trap("basic");
    trap_rdy = 1'b1;
    tick();
    idle_inputs();
    check("basic_done_vld", trap_vld, 0);
    check("basic_done_pending", pending, 0);

    // replacement by older, drop of younger, non-matching commit, stray rdy
    report(1, 6'd10, 16'd1, 64'h10, 64'h0);
    tick();
    idle_inputs();
    check("age_held10", pending_idx, 10);
    report(0, 6'd3, 16'd2, 64'h20, 64'h0);
    tick();
    idle_inputs();
    check("age_older_replaces", pending_idx, 3);
    report(1, 6'd12, 16'd3, 64'h30, 64'h0);
    tick();
    idle_inputs();
    check("age_younger_dropped", pending_idx, 3);
    commit_vld = 1'b1;
    commit_idx = 6'd10;
    tick();
    idle_inputs();
    check("commit_miss_pending", pending, 1);
    check("commit_miss_vld", trap_vld, 0);
    trap_rdy = 1'b1;
    tick();
    idle_inputs();
    check("rdy_in_hold_pending", pending, 1);
    flush = 1'b1;
    tick();
    idle_inputs();
    check("flush_hold_pending", pending, 0);

    // wrap flag ordering
    report(0, {1'b1, 5'd1}, 16'd4, 64'h40, 64'h0);
    tick();
    idle_inputs();
    check("wrap_held", pending_idx, 6'h21);
    report(2, {1'b0, 5'd30}, 16'd4, 64'h50, 64'h0);
    tick();
    idle_inputs();
    check("wrap_replace", pending_idx, 6'd30);
    report(3, {1'b1, 5'd2}, 16'd4, 64'h60, 64'h0);
    tick();
    idle_inputs();
    check("wrap_younger_dropped", pending_idx, 6'd30);
    flush = 1'b1;
    tick();
    idle_inputs();

    // same-cycle oldest selection, then equal-age tie to lowest channel
    report(1, 6'd9, 16'd1, 64'h70, 64'h0);
    report(2, 6'd4, 16'd1, 64'h80, 64'h0);
    report(3, 6'd6, 16'd1, 64'h90, 64'h0);
    tick();
    idle_inputs();
    check("multi_oldest", pending_idx, 4);
    flush = 1'b1;
    tick();
    idle_inputs();
    report(0, 6'd7, 16'd2,  64'h2000, 64'h11);
    report(3, 6'd7, 16'd13, 64'h3000, 64'h22);
    tick();
    idle_inputs();
    commit_push(6'd7, 16'd2, 64'h2000, 64'h11);
    tick();
    idle_inputs();
    expect_trap("tie");
    trap_rdy = 1'b1;
    tick();
    idle_inputs();

    // flush beats commit match
    report(1, 6'd8, 16'd6, 64'ha0, 64'h0);
    tick();
    idle_inputs();
    flush      = 1'b1;
    commit_vld = 1'b1;
    commit_idx = 6'd8;
    tick();
    idle_inputs();
    check("flush_commit_pending", pending, 0);
    check("flush_commit_vld", trap_vld, 0);
    tick();
    check("flush_commit_vld_later", trap_vld, 0);

    // ISSUE held under back-pressure, ignoring reports and flush
    report(3, 6'd2, 16'd7, 64'h4000, 64'h33);
    tick();
    idle_inputs();
    commit_push(6'd2, 16'd7, 64'h4000, 64'h33);
    tick();
    idle_inputs();
    expect_trap("stall");
    for (int c = 0; c < 3; c++) begin
      report(0, 6'd1, 16'd9, 64'hbad, 64'hbad);
      flush = (c == 0);
      tick();
      idle_inputs();
      check("stall_vld", trap_vld, 1);
      check("stall_cause", trap_info.cause, last.cause);
      check("stall_epc", trap_info.epc, last.epc);
      check("stall_idx", pending_idx, last.idx);
    end
    trap_rdy = 1'b1;
    tick();
    idle_inputs();
    check("stall_release_vld", trap_vld, 0);
    check("stall_release_pending", pending, 0);

    // reset in the middle of ISSUE
    report(0, 6'd4, 16'd3, 64'h5000, 64'h44);
    tick();
    idle_inputs();
    commit_vld = 1'b1;
    commit_idx = 6'd4;
    tick();
    idle_inputs();
    check("rst_issue_pre_vld", trap_vld, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_issue_vld", trap_vld, 0);
    check("rst_issue_pending", pending, 0);
    check("rst_issue_idx", pending_idx, 0);
    check("rst_issue_cause", trap_info.cause, 0);
    tick();

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
